// File: rtl/add_sub_sequencer_if.sv
// Issue/result bundle between the FPU issue logic and the add/sub sequencer.
interface add_sub_sequencer_if #(
    parameter int ExpSize  = 8,
    parameter int MantSize = 8
);
    logic                start;
    logic                op;
    logic                sign_a;
    logic                sign_b;
    logic [ExpSize-1:0]  exp_a;
    logic [ExpSize-1:0]  exp_b;
    logic [MantSize-1:0] mant_a;
    logic [MantSize-1:0] mant_b;
    logic                busy;
    logic                done;
    logic                sign_r;
    logic [ExpSize-1:0]  exp_r;
    logic [MantSize-1:0] mant_r;
    logic                overflow;
    logic                underflow;

    modport master (
        output start, op, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
        input  busy, done, sign_r, exp_r, mant_r, overflow, underflow
    );

    modport slave (
        input  start, op, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
        output busy, done, sign_r, exp_r, mant_r, overflow, underflow
    );
endinterface

// File: rtl/add_sub_sequencer.sv
// Multi-cycle FP add/sub sequencer: compare, swap, align, add, normalize.
// Optional macro FPU_ALIGN_SKIP_EN skips alignment when the small operand shifts out entirely.
module add_sub_sequencer #(
    parameter int ExpSize  = 8,
    parameter int MantSize = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    add_sub_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, COMPARE, ALIGN, ADD, NORM, DONE} state_e;

    localparam logic [ExpSize-1:0] EXP_MAX = {ExpSize{1'b1}};

    state_e              state_q;
    logic                sign_a_q, sign_b_q, sign_l_q, eff_sub_q;
    logic [ExpSize-1:0]  exp_a_q, exp_b_q, exp_l_q, diff_q;
    logic [MantSize-1:0] mant_a_q, mant_b_q, mant_l_q, mant_s_q;
    logic [MantSize:0]   sum_q;
    logic                busy_q, done_q, sign_r_q, ovf_q, unf_q;
    logic [ExpSize-1:0]  exp_r_q;
    logic [MantSize-1:0] mant_r_q;

    logic                a_large_d;
    logic [ExpSize-1:0]  diff_d;
    logic [MantSize-1:0] mant_s_d;
    logic [MantSize:0]   sum_d;

    // Equal magnitudes count as A-large, so ML-MS never goes negative.
    always_comb begin
        a_large_d = (exp_a_q > exp_b_q) || ((exp_a_q == exp_b_q) && !(mant_b_q > mant_a_q));
        diff_d    = a_large_d ? (exp_a_q - exp_b_q) : (exp_b_q - exp_a_q);
        mant_s_d  = a_large_d ? mant_b_q : mant_a_q;
        sum_d     = eff_sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                              : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            sign_l_q  <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_a_q   <= '0;
            exp_b_q   <= '0;
            exp_l_q   <= '0;
            diff_q    <= '0;
            mant_a_q  <= '0;
            mant_b_q  <= '0;
            mant_l_q  <= '0;
            mant_s_q  <= '0;
            sum_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sign_r_q  <= 1'b0;
            exp_r_q   <= '0;
            mant_r_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sign_a_q <= bus.sign_a;
                        sign_b_q <= bus.sign_b ^ bus.op;
                        exp_a_q  <= (bus.mant_a == '0) ? '0 : bus.exp_a;
                        exp_b_q  <= (bus.mant_b == '0) ? '0 : bus.exp_b;
                        mant_a_q <= bus.mant_a;
                        mant_b_q <= bus.mant_b;
                        busy_q   <= 1'b1;
                        state_q  <= COMPARE;
                    end
                end
                COMPARE: begin
                    sign_l_q  <= a_large_d ? sign_a_q : sign_b_q;
                    eff_sub_q <= sign_a_q ^ sign_b_q;
                    exp_l_q   <= a_large_d ? exp_a_q : exp_b_q;
                    mant_l_q  <= a_large_d ? mant_a_q : mant_b_q;
                    mant_s_q  <= mant_s_d;
                    diff_q    <= diff_d;
`ifdef FPU_ALIGN_SKIP_EN
                    if (32'(diff_d) > 32'(MantSize)) begin
                        mant_s_q <= '0;
                        diff_q   <= '0;
                        state_q  <= ADD;
                    end else begin
                        state_q <= (diff_d != '0 && mant_s_d != '0) ? ALIGN : ADD;
                    end
`else
                    state_q <= (diff_d != '0 && mant_s_d != '0) ? ALIGN : ADD;
`endif
                end
                ALIGN: begin
                    mant_s_q <= mant_s_q >> 1;
                    diff_q   <= diff_q - 1'b1;
                    if (diff_q == ExpSize'(1) || (mant_s_q >> 1) == '0)
                        state_q <= ADD;
                end
                ADD: begin
                    sum_q   <= sum_d;
                    state_q <= NORM;
                end
                NORM: begin
                    if (sum_q == '0) begin
                        {sign_r_q, exp_r_q, mant_r_q, ovf_q, unf_q} <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (sum_q[MantSize]) begin
                        // exp+1 hitting all ones saturates instead of normalizing
                        if (exp_l_q >= EXP_MAX - 1'b1) begin
                            sign_r_q <= sign_l_q;
                            exp_r_q  <= EXP_MAX;
                            mant_r_q <= '0;
                            ovf_q    <= 1'b1;
                            unf_q    <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            sum_q   <= sum_q >> 1;
                            exp_l_q <= exp_l_q + 1'b1;
                        end
                    end else if (!sum_q[MantSize-1]) begin
                        if (exp_l_q <= ExpSize'(1)) begin
                            {sign_r_q, exp_r_q, mant_r_q, ovf_q} <= '0;
                            unf_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            sum_q   <= sum_q << 1;
                            exp_l_q <= exp_l_q - 1'b1;
                        end
                    end else begin
                        sign_r_q <= sign_l_q;
                        exp_r_q  <= exp_l_q;
                        mant_r_q <= sum_q[MantSize-1:0];
                        ovf_q    <= 1'b0;
                        unf_q    <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sign_r    = sign_r_q;
    assign bus.exp_r     = exp_r_q;
    assign bus.mant_r    = mant_r_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule
